// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between NUM_REQ requesters.
// Each granted word is sent LSB-first, one byte per tx_ena strobe, paced by tx_busy.
module uart_tx_sched #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int START_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]          req_len,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    owner,
    output logic                          busy,
    output logic                          tx_ena,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy
);

    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              ptr_reg, ptr_next;
    logic [2:0]              owner_reg, owner_next;
    logic [DATA_WIDTH-1:0]   word_reg, word_next;
    logic [1:0]              len_reg, len_next;
    logic [1:0]              byte_idx_reg, byte_idx_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]      ack_reg, ack_next;
    logic                    done_reg, done_next;
    logic                    err_reg, err_next;
    logic                    tx_ena_reg, tx_ena_next;
    logic [7:0]              tx_data_reg, tx_data_next;

    // Requester inputs padded to the full 8-entry owner space so a 3-bit index is always in range.
    logic [7:0]              req_pad;
    logic [DATA_WIDTH-1:0]   word_arr [8];
    logic [1:0]              len_arr  [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_used
                assign req_pad[gi]  = req[gi];
                assign word_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
                assign len_arr[gi]  = req_len[gi*2 +: 2];
            end else begin : g_unused
                assign req_pad[gi]  = 1'b0;
                assign word_arr[gi] = '0;
                assign len_arr[gi]  = '0;
            end
        end
    endgenerate

    logic       grant_found;
    logic [2:0] grant_idx;
    logic [3:0] cand;
    logic [7:0] ack_onehot;

    // First pending requester at or above the RR pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!grant_found && req_pad[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
        ack_onehot = 8'd1 << grant_idx;
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        word_next     = word_reg;
        len_next      = len_reg;
        byte_idx_next = byte_idx_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        tx_ena_next   = 1'b0;
        tx_data_next  = tx_data_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next    = ISSUE;
                    owner_next    = grant_idx;
                    word_next     = word_arr[grant_idx];
                    len_next      = len_arr[grant_idx];
                    byte_idx_next = '0;
                    ack_next      = ack_onehot[NUM_REQ-1:0];
                    ptr_next      = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
                end
            end
            ISSUE: begin
                if (!tx_busy) begin
                    tx_ena_next  = 1'b1;
                    tx_data_next = word_reg[{byte_idx_reg, 3'b000} +: 8];
                    cnt_next     = '0;
                    state_next   = WAIT_START;
                end
            end
            WAIT_START: begin
                // A UART that never acknowledges the strobe drops the rest of the word.
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CW'(START_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (byte_idx_reg == len_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        state_next    = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            word_reg     <= '0;
            len_reg      <= '0;
            byte_idx_reg <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            tx_ena_reg   <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            word_reg     <= word_next;
            len_reg      <= len_next;
            byte_idx_reg <= byte_idx_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            tx_ena_reg   <= tx_ena_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    assign ack     = ack_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign owner   = owner_reg;
    assign busy    = (state_reg != IDLE);
    assign tx_ena  = tx_ena_reg;
    assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scenario bench for uart_tx_sched: directed cases plus randomized multi-requester traffic
// checked against a round-robin byte-stream model.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_len = '0;
    logic [1:0]  ack;
    logic        done, err, busy, tx_ena;
    logic [2:0]  owner;
    logic [7:0]  tx_data;
    logic        tx_busy;

    int errors = 0;
    int checks = 0;

    uart_tx_sched #(.NUM_REQ(2), .DATA_WIDTH(32), .START_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_len(req_len),
        .ack(ack), .done(done), .err(err), .owner(owner), .busy(busy),
        .tx_ena(tx_ena), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // UART model: busy for busy_len cycles after sampling a start strobe.
    int   busy_len = 10;
    bit   uart_dead = 0;
    bit   force_busy = 0;
    logic uart_busy = 1'b0;
    int   uart_cnt = 0;
    int   cyc = 0;
    assign tx_busy = uart_busy | force_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_busy <= 1'b0;
        end else if (tx_ena && !uart_dead) begin
            uart_busy <= 1'b1;
            uart_cnt  <= busy_len;
        end
    end

    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         ack_log[$];
    int         done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1, fall_cyc = -1;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (tx_ena) begin
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        for (int i = 0; i < 2; i++) if (ack[i]) ack_log.push_back(i);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    end

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete(); ack_log.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic apply_reset();
        uart_dead = 0; force_busy = 0; req = '0;
        for (int t = 0; t < 200 && tx_busy; t++) @(negedge clk);
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic run_word(input int i, input logic [31:0] d, input logic [1:0] l, output bit ok);
        req_data[i*32 +: 32] = d;
        req_len[i*2 +: 2] = l;
        req[i] = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (ack[i]) begin ok = 1; break; end
        end
        req[i] = 1'b0;
        if (ok) begin
            ok = 0;
            for (int t = 0; t < 2000; t++) begin
                if (done_cnt > 0) begin ok = 1; break; end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, done, err, tx_ena, busy, owner} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", {ack, done, err, tx_ena, busy, owner});
        end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        $display("reset: outputs idle");
    endtask

    task automatic test_single_word();
        bit ok;
        logic [31:0] d = 32'h44332211;
        apply_reset(); busy_len = 10;
        run_word(0, d, 2'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no done want done"); end
        checks++;
        if (ack_log.size() != 1 || ack_log[0] != 0) begin
            errors++; $display("FAIL single_ack: got %0d acks want 1 ack on req0", ack_log.size());
        end
        checks++;
        if (tx_log.size() != 4) begin errors++; $display("FAIL single_nbytes: got %0d want 4", tx_log.size()); end
        for (int k = 0; k < tx_log.size() && k < 4; k++) begin
            checks++;
            if (tx_log[k] !== d[8*k +: 8]) begin
                errors++; $display("FAIL single_byte%0d: got %h want %h", k, tx_log[k], d[8*k +: 8]);
            end
        end
        checks++;
        if (done_cyc != fall_cyc + 1) begin
            errors++; $display("FAIL single_done_time: got cycle %0d want %0d", done_cyc, fall_cyc + 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL single_done_err: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
        end
        $display("single word: %0d bytes sent", tx_log.size());
    endtask

    task automatic test_short_len();
        bit ok;
        apply_reset(); busy_len = 10;
        run_word(0, 32'hA5A5A5C3, 2'd0, ok);
        repeat (15) @(negedge clk);
        checks++;
        if (!ok || done_cnt != 1) begin errors++; $display("FAIL short_done: got %0d want 1", done_cnt); end
        checks++;
        if (tx_log.size() != 1) begin errors++; $display("FAIL short_nbytes: got %0d want 1", tx_log.size()); end
        else begin
            checks++;
            if (tx_log[0] !== 8'hC3) begin errors++; $display("FAIL short_byte: got %h want c3", tx_log[0]); end
        end
        $display("short word: %0d byte sent", tx_log.size());
    endtask

    task automatic test_contention();
        int exp_own[4];
        int p = 0;
        apply_reset(); busy_len = 5;
        req_data = {32'h000000BB, 32'h000000AA};
        req_len = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            exp_own[k] = p;  // both always pending: pointer position wins
            p = (p + 1) % 2;
        end
        req = 2'b11;
        for (int t = 0; t < 2000 && ack_log.size() < 4; t++) begin @(negedge clk); #1; end
        req = 2'b00;
        for (int t = 0; t < 2000 && done_cnt < 4; t++) begin @(negedge clk); #1; end
        checks++;
        if (done_cnt != 4 || ack_log.size() != 4) begin
            errors++; $display("FAIL contend_count: got acks=%0d dones=%0d want 4/4", ack_log.size(), done_cnt);
        end
        for (int k = 0; k < ack_log.size() && k < 4; k++) begin
            checks++;
            if (ack_log[k] != exp_own[k]) begin
                errors++; $display("FAIL contend_grant%0d: got %0d want %0d", k, ack_log[k], exp_own[k]);
            end
        end
        for (int k = 0; k < tx_log.size() && k < 4; k++) begin
            checks++;
            if (tx_log[k] !== (exp_own[k] == 0 ? 8'hAA : 8'hBB)) begin
                errors++; $display("FAIL contend_byte%0d: got %h want %h", k, tx_log[k], (exp_own[k] == 0 ? 8'hAA : 8'hBB));
            end
        end
        $display("contention: grants %0d words", ack_log.size());
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset();
        uart_dead = 1;
        run_word(1, 32'h87654321, 2'd3, ok);
        checks++;
        if (!ok || done_cnt != 1 || err_cnt != 1) begin
            errors++; $display("FAIL timeout_pulses: got done=%0d err=%0d want 1/1", done_cnt, err_cnt);
        end
        checks++;
        if (err_cyc != done_cyc) begin errors++; $display("FAIL timeout_coincide: got err@%0d done@%0d want equal", err_cyc, done_cyc); end
        if (tx_cyc.size() > 0) begin
            checks++;
            if (done_cyc - tx_cyc[0] != 16) begin
                errors++; $display("FAIL timeout_delay: got %0d want 16", done_cyc - tx_cyc[0]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
        repeat (30) @(negedge clk);
        checks++;
        if (tx_log.size() != 1) begin errors++; $display("FAIL timeout_nbytes: got %0d want 1", tx_log.size()); end
        uart_dead = 0;
        $display("timeout: err after %0d cycles", done_cyc - (tx_cyc.size() > 0 ? tx_cyc[0] : 0));
    endtask

    task automatic test_prebusy();
        int rel;
        apply_reset(); busy_len = 4;
        force_busy = 1;
        req_data[31:0] = 32'h0000005A; req_len[1:0] = 2'd0; req = 2'b01;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (ack[0]) req = 2'b00;
        end
        checks++;
        if (tx_log.size() != 0 || busy !== 1'b1 || ack_log.size() != 1) begin
            errors++; $display("FAIL prebusy_hold: got tx=%0d busy=%b acks=%0d want 0/1/1", tx_log.size(), busy, ack_log.size());
        end
        force_busy = 0;
        rel = cyc;
        for (int t = 0; t < 100 && done_cnt == 0; t++) begin @(negedge clk); #1; end
        checks++;
        if (tx_cyc.size() != 1 || tx_cyc[0] != rel + 1) begin
            errors++; $display("FAIL prebusy_fire: got %0d strobes first@%0d want 1 @%0d", tx_cyc.size(), (tx_cyc.size() > 0 ? tx_cyc[0] : -1), rel + 1);
        end
        $display("prebusy: tx_ena after release");
    endtask

    task automatic test_reset_mid();
        int first;
        for (int v = 0; v < 2; v++) begin
            apply_reset(); busy_len = 10;
            req_data[31:0] = 32'h44332211; req_len[1:0] = 2'd3; req = 2'b01;
            for (int t = 0; t < 100 && ack_log.size() == 0; t++) begin @(negedge clk); #1; end
            req = 2'b00;
            for (int t = 0; t < 200 && tx_log.size() < 2; t++) begin @(negedge clk); #1; end
            reset_n = 1'b0;
            @(negedge clk); #1;
            checks++;
            if ({ack, done, err, tx_ena, busy, owner, tx_data} !== 17'd0) begin
                errors++; $display("FAIL midreset_outputs: got %h want 0", {ack, done, err, tx_ena, busy, owner, tx_data});
            end
            reset_n = 1'b1;
            repeat (15) @(negedge clk);
            checks++;
            if (done_cnt != 0 || err_cnt != 0) begin
                errors++; $display("FAIL midreset_nodone: got done=%0d err=%0d want 0/0", done_cnt, err_cnt);
            end
            clear_logs();
            req_data = {32'h00000022, 32'h00000011}; req_len = 4'b0000;
            req = (v == 0) ? 2'b10 : 2'b11;
            first = -1;
            for (int t = 0; t < 100 && ack_log.size() == 0; t++) begin @(negedge clk); #1; end
            if (ack_log.size() > 0) first = ack_log[0];
            req = 2'b00;
            for (int t = 0; t < 200 && done_cnt == 0; t++) begin @(negedge clk); #1; end
            checks++;
            if (first != ((v == 0) ? 1 : 0)) begin
                errors++; $display("FAIL midreset_grant%0d: got %0d want %0d", v, first, (v == 0) ? 1 : 0);
            end
            checks++;
            if (tx_log.size() != 1 || tx_log[0] !== ((v == 0) ? 8'h22 : 8'h11)) begin
                errors++; $display("FAIL midreset_byte%0d: got %0d bytes want one %h", v, tx_log.size(), (v == 0) ? 8'h22 : 8'h11);
            end
            $display("reset mid-word variant %0d: first grant %0d", v, first);
        end
    endtask

    task automatic test_random();
        int         p = 0;
        int         exp_own[$];
        logic [7:0] exp_bytes[$];
        logic [31:0] w[2];
        logic [1:0]  l[2];
        logic [1:0]  mask, m;
        apply_reset();
        for (int it = 0; it < 12; it++) begin
            mask = 2'($urandom_range(1, 3));
            busy_len = $urandom_range(1, 6);
            exp_own.delete(); exp_bytes.delete();
            for (int i = 0; i < 2; i++) begin
                w[i] = $urandom;
                l[i] = 2'($urandom_range(0, 3));
            end
            // Reference: repeatedly serve the first pending requester from the pointer.
            m = mask;
            while (m != 0) begin
                int c = m[p] ? p : (p + 1) % 2;
                exp_own.push_back(c);
                for (int k = 0; k <= int'(l[c]); k++) exp_bytes.push_back(w[c][8*k +: 8]);
                m[c] = 1'b0;
                p = (c + 1) % 2;
            end
            clear_logs();
            req_data = {w[1], w[0]};
            req_len = {l[1], l[0]};
            req = mask;
            for (int t = 0; t < 3000 && done_cnt < exp_own.size(); t++) begin
                @(negedge clk); #1;
                req = req & ~ack;
            end
            req = 2'b00;
            checks++;
            if (ack_log.size() != exp_own.size() || done_cnt != exp_own.size() || err_cnt != 0) begin
                errors++; $display("FAIL rand%0d_count: got acks=%0d dones=%0d errs=%0d want %0d/%0d/0",
                                   it, ack_log.size(), done_cnt, err_cnt, exp_own.size(), exp_own.size());
            end
            for (int k = 0; k < ack_log.size() && k < exp_own.size(); k++) begin
                checks++;
                if (ack_log[k] != exp_own[k]) begin
                    errors++; $display("FAIL rand%0d_grant%0d: got %0d want %0d", it, k, ack_log[k], exp_own[k]);
                end
            end
            checks++;
            if (tx_log.size() != exp_bytes.size()) begin
                errors++; $display("FAIL rand%0d_nbytes: got %0d want %0d", it, tx_log.size(), exp_bytes.size());
            end
            for (int k = 0; k < tx_log.size() && k < exp_bytes.size(); k++) begin
                checks++;
                if (tx_log[k] !== exp_bytes[k]) begin
                    errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, k, tx_log[k], exp_bytes[k]);
                end
            end
            $display("random %0d: mask=%b words=%0d bytes=%0d", it, mask, exp_own.size(), exp_bytes.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_short_len();
        test_contention();
        test_timeout();
        test_prebusy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
